// File: rtl/cam_i2c_pkg.sv
// Shared types and constants for the camera-bus I2C target.
package cam_i2c_pkg;

    localparam int BYTE_W = 8;
    localparam int PTR_W  = 16;

    // Value of the R/W bit in the address byte
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR_H,
        ST_PTR_H_ACK,
        ST_PTR_L,
        ST_PTR_L_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RD_MACK,
        ST_IGNORE
    } state_t;

    // Receive state that follows a write-path ACK state
    function automatic state_t after_write_ack(state_t s);
        case (s)
            ST_PTR_H_ACK: return ST_PTR_L;
            ST_PTR_L_ACK: return ST_WDATA;
            ST_WDATA_ACK: return ST_WDATA;
            default:      return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/cam_i2c_target_if.sv
// Bus bundle between the I2C target and its environment: pad lines,
// register strobe port and busy flag.
interface cam_i2c_target_if;
    import cam_i2c_pkg::*;

    logic              scl_in;
    logic              sda_in;
    logic              sda_oe;
    logic              wr_stb;
    logic              rd_stb;
    logic [PTR_W-1:0]  reg_addr;
    logic [BYTE_W-1:0] wr_data;
    logic [BYTE_W-1:0] rd_data;
    logic              busy;

    // Target side (the DUT)
    modport slave (
        input  scl_in, sda_in, rd_data,
        output sda_oe, wr_stb, rd_stb, reg_addr, wr_data, busy
    );

    // Environment side: bus master plus register file
    modport master (
        output scl_in, sda_in, rd_data,
        input  sda_oe, wr_stb, rd_stb, reg_addr, wr_data, busy
    );

endinterface

// File: rtl/i2c_line_filter.sv
// Input conditioning for one I2C line: 2-FF synchroniser, glitch filter
// that accepts a new level only after it held for FILTER_LEN clocks, and
// single-cycle rise/fall flags aligned with the filtered level change.
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count how long the synced level has disagreed with the accepted one
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchroniser and filter state; idle bus level is high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/cam_i2c_target.sv
// I2C target standing in for the camera sensor: address match, 16-bit
// register pointer, write bursts with auto-increment, reads via repeated
// START, all through a single-cycle strobe register port.
module cam_i2c_target
    import cam_i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = 7'h10,
    parameter int         FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    cam_i2c_target_if.slave bus
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk(clk), .reset(reset), .line_i(bus.scl_in),
        .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk(clk), .reset(reset), .line_i(bus.sda_in),
        .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    state_t            state_q, state_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              rw_q, rw_d;
    logic              sda_oe_q, sda_oe_d;
    logic              wr_stb_q, wr_stb_d;
    logic              rd_stb_q, rd_stb_d;
    logic              rd_pend_q, rd_pend_d;
    logic [PTR_W-1:0]  reg_addr_q, reg_addr_d;
    logic [BYTE_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, busy_d;

    logic              start_ev, stop_ev, last_bit;
    logic [BYTE_W-1:0] rx_byte;

    assign start_ev = scl_lvl & sda_fall;
    assign stop_ev  = scl_lvl & sda_rise;
    assign rx_byte  = {shift_q[BYTE_W-2:0], sda_lvl};
    assign last_bit = (bit_cnt_q == 4'd7);

    // Next-state logic: bus events first (STOP beats START beats data), then per-state work
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        wr_stb_d   = 1'b0;
        rd_stb_d   = 1'b0;
        rd_pend_d  = rd_stb_q;
        reg_addr_d = reg_addr_q;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;

        // Read data arrives one clock after the request; it becomes the byte to shift out
        if (rd_pend_q) begin
            shift_d = bus.rd_data;
            ptr_d   = ptr_q + 16'd1;
        end

        if (stop_ev) begin
            state_d   = ST_IDLE;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = '0;
        end else if (start_ev) begin
            state_d   = ST_ADDR;
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_IGNORE: begin
                end

                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = last_bit ? 4'd0 : bit_cnt_q + 4'd1;
                        if (last_bit) begin
                            if (rx_byte[7:1] == DEV_ADDR) begin
                                state_d = ST_ADDR_ACK;
                                rw_d    = rx_byte[0];
                                busy_d  = 1'b1;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end

                ST_ADDR_ACK: begin
                    // A read fetches its first byte on the ACK clock itself
                    if (scl_rise && sda_oe_q && rw_q == RW_READ) begin
                        rd_stb_d   = 1'b1;
                        reg_addr_d = ptr_q;
                    end
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else if (rw_q == RW_READ) begin
                            state_d   = ST_RDATA;
                            sda_oe_d  = ~shift_q[7];
                            bit_cnt_d = '0;
                        end else begin
                            state_d  = ST_PTR_H;
                            sda_oe_d = 1'b0;
                        end
                    end
                end

                ST_PTR_H, ST_PTR_L, ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = last_bit ? 4'd0 : bit_cnt_q + 4'd1;
                        if (last_bit) begin
                            if (state_q == ST_PTR_H) begin
                                ptr_d[15:8] = rx_byte;
                                state_d     = ST_PTR_H_ACK;
                            end else if (state_q == ST_PTR_L) begin
                                ptr_d[7:0] = rx_byte;
                                state_d    = ST_PTR_L_ACK;
                            end else begin
                                wr_stb_d   = 1'b1;
                                reg_addr_d = ptr_q;
                                wr_data_d  = rx_byte;
                                ptr_d      = ptr_q + 16'd1;
                                state_d    = ST_WDATA_ACK;
                            end
                        end
                    end
                end

                ST_PTR_H_ACK, ST_PTR_L_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = after_write_ack(state_q);
                        end
                    end
                end

                ST_RDATA: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            state_d   = ST_RD_MACK;
                            bit_cnt_d = '0;
                        end else begin
                            sda_oe_d = ~shift_q[~bit_cnt_q[2:0]];
                        end
                    end
                end

                ST_RD_MACK: begin
                    if (scl_rise) begin
                        if (sda_lvl) begin
                            state_d = ST_IGNORE;
                        end else begin
                            rd_stb_d   = 1'b1;
                            reg_addr_d = ptr_q;
                        end
                    end
                    // Only reached when the master ACKed: a NACK left on the rise
                    if (scl_fall) begin
                        state_d   = ST_RDATA;
                        sda_oe_d  = ~shift_q[7];
                        bit_cnt_d = '0;
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers; reset releases SDA immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            ptr_q      <= '0;
            rw_q       <= RW_WRITE;
            sda_oe_q   <= 1'b0;
            wr_stb_q   <= 1'b0;
            rd_stb_q   <= 1'b0;
            rd_pend_q  <= 1'b0;
            reg_addr_q <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            wr_stb_q   <= wr_stb_d;
            rd_stb_q   <= rd_stb_d;
            rd_pend_q  <= rd_pend_d;
            reg_addr_q <= reg_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.sda_oe   = sda_oe_q;
    assign bus.wr_stb   = wr_stb_q;
    assign bus.rd_stb   = rd_stb_q;
    assign bus.reg_addr = reg_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.busy     = busy_q;

endmodule
